quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
Parametrised quadrature decoder, successor to the basic 32-bit encoder counter. Synchronises and glitch-filters A/B/Z encoder inputs, then x4-decodes to a signed position count. Adds preset load, index capture, optional zero-on-index, sticky fault with counter, and windowed velocity. Sits between the encoder pins and the motion-control register file.

Parameters:
WIDTH, 32, position counter width (two's complement, wraps)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILTER_LEN, 3, consecutive identical synced samples needed to accept a new level (>=1)
VEL_WINDOW, 1000, clocks per velocity measurement window (>=2)
VEL_WIDTH, 16, velocity output width (signed, saturating)
ERR_WIDTH, 8, fault-event counter width (saturating)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
a  in  1  encoder channel A (asynchronous pin)
b  in  1  encoder channel B (asynchronous pin)
z  in  1  encoder index (asynchronous pin)
load  in  1  one-cycle strobe: count <= load_value
load_value  in  WIDTH  preset value
idx_clr_en  in  1  when 1, count cleared on index rising edge
fault_clr  in  1  one-cycle strobe: clear fault and err_count
count  out  WIDTH  signed position
dir  out  1  direction of last valid step (1 = forward)
step  out  1  one-cycle pulse per valid step
fault  out  1  sticky illegal-transition flag
err_count  out  ERR_WIDTH  illegal transitions seen, saturating
index_pos  out  WIDTH  count captured at last index edge
index_strobe  out  1  one-cycle pulse on index capture
velocity  out  VEL_WIDTH  net steps in last completed window
vel_strobe  out  1  one-cycle pulse when velocity updates

Behaviour:
- Reset (async assert, sync release): all outputs 0; filter states load 0; window counter 0.
- Each input: SYNC_STAGES flops, then filter: run counter increments while synced != filtered, clears when equal; filtered toggles when run reaches FILTER_LEN. Pulses shorter than FILTER_LEN clocks never pass.
- Decode: state {A,B} filtered, registered prev. Forward (+1): 00->10->11->01->00. Reverse (-1): opposite order. No change: hold.
- Both bits change same cycle: illegal; count and dir unchanged, no step, fault <= 1, err_count +1 (saturates at all-ones).
- Latency: count updates SYNC_STAGES+FILTER_LEN+1 clock edges after the first edge sampling the new pin level (6 at defaults).
- Count wraps modulo 2^WIDTH, no saturation.
- Index: rising edge of filtered z -> index_pos <= count value before this cycle's update, index_strobe = 1 for one cycle. If idx_clr_en: count <= 0 that cycle, overriding any step.
- Count priority per cycle: load > index clear > step. Step coincident with load or clear is discarded but step pulse, dir and velocity still account for it.
- fault_clr: fault <= 0, err_count <= 0; an illegal transition in the same cycle wins (fault = 1, err_count = 1).
- Velocity: window counter 0..VEL_WINDOW-1; signed accumulator +/-1 per step, saturating at VEL_WIDTH limits. On terminal count: velocity <= accumulator (including that cycle's step), vel_strobe = 1, accumulator restarts at 0. Load/index do not disturb velocity.
- Reset mid-operation: everything returns to reset values immediately; first post-reset filtered state is 00, so an encoder resting at 11 after reset produces a fault (documented, intended).

Decomposition:
- Package quad_decoder_pkg: state encoding constants (ST_00, ST_10, ST_11, ST_01), step-direction enum (STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL), decode function prev/cur -> enum.
- Sub-module quad_input_filter (params SYNC_STAGES, FILTER_LEN): one pin in, filtered level out; instantiated three times (a, b, z).

Test Plan:
- 8 forward quadrature cycles (32 edges, 20 clk/edge) from reset -> count = 32, dir = 1, 32 step pulses; repeat reverse -> count = 0, dir = 0.
- Single A edge at defaults -> count changes exactly 6 clocks after sampling; 2-clock glitch on B -> no change in count, step, or fault.
- A and B toggled on the same clock (state 00->11) -> count held, fault = 1, err_count = 1; 300 more such events -> err_count = 255; fault_clr -> both 0.
- count = 100, idx_clr_en = 0, z rising -> index_pos = 100, index_strobe one cycle, count unchanged; idx_clr_en = 1 -> count = 0 after edge.
- load with load_value = 32'hFFFF_FFFF, then one forward step -> count = 0 (wrap); load coincident with step -> count = load_value.
- VEL_WINDOW = 100, forward step every 4 clocks -> velocity = 25 each window, vel_strobe every 100 clocks; assert reset mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/quad_decoder_pkg.sv
// Shared quadrature state encodings and the prev/cur transition classifier.
// Pure combinational helpers; no storage.
package quad_decoder_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00; any single-bit move that is
  // not the forward successor must be the reverse one.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e r;
    logic [1:0] fwd_next;
    r = STEP_NONE;
    case (prev)
      ST_00:   fwd_next = ST_10;
      ST_10:   fwd_next = ST_11;
      ST_11:   fwd_next = ST_01;
      default: fwd_next = ST_00;
    endcase
    if (prev == cur)
      r = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      r = STEP_ILLEGAL;
    else if (cur == fwd_next)
      r = STEP_FWD;
    else
      r = STEP_REV;
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pins, host controls and decoded position/velocity outputs as one bundle.
// master drives pins and controls; slave is the decoder.
interface quad_decoder_if #(
  parameter int WIDTH     = 32,
  parameter int VEL_WIDTH = 16,
  parameter int ERR_WIDTH = 8
);
  logic                 a;
  logic                 b;
  logic                 z;
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic                 idx_clr_en;
  logic                 fault_clr;
  logic [WIDTH-1:0]     count;
  logic                 dir;
  logic                 step;
  logic                 fault;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     index_pos;
  logic                 index_strobe;
  logic [VEL_WIDTH-1:0] velocity;
  logic                 vel_strobe;

  modport master (
    output a, b, z, load, load_value, idx_clr_en, fault_clr,
    input  count, dir, step, fault, err_count, index_pos, index_strobe, velocity, vel_strobe
  );

  modport slave (
    input  a, b, z, load, load_value, idx_clr_en, fault_clr,
    output count, dir, step, fault, err_count, index_pos, index_strobe, velocity, vel_strobe
  );
endinterface

// File: rtl/quad_input_filter.sv
// Synchroniser plus run-length glitch filter for one asynchronous encoder pin.
// Latency SYNC_STAGES+FILTER_LEN edges; pulses shorter than FILTER_LEN clocks are dropped.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);
  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RUN_W-1:0]       run_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      run_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (synced == level) begin
        run_q <= '0;
      end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        level <= synced;
        run_q <= '0;
      end else begin
        run_q <= run_q + RUN_W'(1);
      end
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B/Z to signed count, index capture, fault count, velocity.
// Count follows a pin edge by SYNC_STAGES+FILTER_LEN+1 clocks; no backpressure, outputs are strobes.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int VEL_WINDOW  = 1000,
  parameter int VEL_WIDTH   = 16,
  parameter int ERR_WIDTH   = 8
) (
  input logic          clk,
  input logic          reset,
  quad_decoder_if.slave io
);
  localparam int WIN_W = $clog2(VEL_WINDOW);
  localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic [1:0] rst_sync_q;
  logic       rst_i;

  // Assert immediately, release two clocks after the pin drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_i = rst_sync_q[1];

  logic fa, fb, fz;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(rst_i), .pin(io.a), .level(fa));
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(rst_i), .pin(io.b), .level(fb));
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .reset(rst_i), .pin(io.z), .level(fz));

  logic [1:0]           prev_q;
  logic                 z_prev_q;
  logic [WIDTH-1:0]     count_q, count_nxt, index_pos_q;
  logic                 dir_q, step_q, fault_q, fault_nxt, index_strobe_q, vel_strobe_q;
  logic [ERR_WIDTH-1:0] err_q, err_nxt;
  logic [VEL_WIDTH-1:0] acc_q, acc_step, vel_q;
  logic [WIN_W-1:0]     win_q;
  logic [1:0]           cur;
  step_e                step_kind;
  logic                 is_fwd, is_rev, is_ill, idx_edge, win_end;

  assign cur = {fa, fb};

  always_comb begin
    step_kind = decode_step(prev_q, cur);
    is_fwd    = (step_kind == STEP_FWD);
    is_rev    = (step_kind == STEP_REV);
    is_ill    = (step_kind == STEP_ILLEGAL);
    idx_edge  = fz & ~z_prev_q;
    win_end   = (win_q == WIN_W'(VEL_WINDOW - 1));

    // Later assignments take priority: load > index clear > step.
    count_nxt = count_q;
    if (is_fwd)      count_nxt = count_q + WIDTH'(1);
    else if (is_rev) count_nxt = count_q - WIDTH'(1);
    if (idx_edge && io.idx_clr_en) count_nxt = '0;
    if (io.load)                   count_nxt = io.load_value;

    fault_nxt = fault_q;
    err_nxt   = err_q;
    if (io.fault_clr) begin
      fault_nxt = 1'b0;
      err_nxt   = '0;
    end
    if (is_ill) begin
      fault_nxt = 1'b1;
      if (io.fault_clr)    err_nxt = ERR_WIDTH'(1);
      else if (err_q != '1) err_nxt = err_q + ERR_WIDTH'(1);
    end

    acc_step = acc_q;
    if (is_fwd && acc_q != VEL_MAX)      acc_step = acc_q + VEL_WIDTH'(1);
    else if (is_rev && acc_q != VEL_MIN) acc_step = acc_q - VEL_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      prev_q         <= ST_00;
      z_prev_q       <= 1'b0;
      count_q        <= '0;
      dir_q          <= 1'b0;
      step_q         <= 1'b0;
      fault_q        <= 1'b0;
      err_q          <= '0;
      index_pos_q    <= '0;
      index_strobe_q <= 1'b0;
      acc_q          <= '0;
      vel_q          <= '0;
      vel_strobe_q   <= 1'b0;
      win_q          <= '0;
    end else begin
      prev_q         <= cur;
      z_prev_q       <= fz;
      count_q        <= count_nxt;
      step_q         <= is_fwd | is_rev;
      if (is_fwd | is_rev) dir_q <= is_fwd;
      fault_q        <= fault_nxt;
      err_q          <= err_nxt;
      index_strobe_q <= idx_edge;
      if (idx_edge) index_pos_q <= count_q;
      if (win_end) begin
        win_q        <= '0;
        vel_q        <= acc_step;
        vel_strobe_q <= 1'b1;
        acc_q        <= '0;
      end else begin
        win_q        <= win_q + WIN_W'(1);
        vel_strobe_q <= 1'b0;
        acc_q        <= acc_step;
      end
    end
  end

  assign io.count        = count_q;
  assign io.dir          = dir_q;
  assign io.step         = step_q;
  assign io.fault        = fault_q;
  assign io.err_count    = err_q;
  assign io.index_pos    = index_pos_q;
  assign io.index_strobe = index_strobe_q;
  assign io.velocity     = vel_q;
  assign io.vel_strobe   = vel_strobe_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stimulus pushes expected step/index results,
// negedge monitors pop and compare whenever the decoder strobes.
module tb_quad_decoder;
  localparam int WIDTH      = 32;
  localparam int VEL_WIDTH  = 16;
  localparam int ERR_WIDTH  = 8;
  localparam int VEL_WINDOW = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  quad_decoder_if #(.WIDTH(WIDTH), .VEL_WIDTH(VEL_WIDTH), .ERR_WIDTH(ERR_WIDTH)) io ();

  quad_decoder #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER_LEN(3), .VEL_WINDOW(VEL_WINDOW),
    .VEL_WIDTH(VEL_WIDTH), .ERR_WIDTH(ERR_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .io(io)
  );

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic             dir;
  } step_exp_t;

  step_exp_t        step_q[$];
  logic [WIDTH-1:0] idx_q[$];
  step_exp_t        mon_e;
  logic [WIDTH-1:0] mon_idx;
  int               ntests = 0;
  int               nfail = 0;
  int               steps_seen = 0;
  int               idx_seen = 0;
  int               s0;
  logic             idx_prev = 1'b0;
  longint           cyc = 0;
  bit               pa = 1'b0, pb = 1'b0;
  logic [WIDTH-1:0] cnt_m = '0;
  bit               vel_done = 1'b0;
  bit               vel_ok;
  longint           t_prev, t_now;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {io.count, io.dir, io.step, io.fault, io.err_count, io.index_pos,
               io.index_strobe, io.velocity, io.vel_strobe}, 128'd0);
  endtask

  // Scoreboard side: every step or index strobe must match a queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (io.step) begin
        steps_seen++;
        chk("step_expected_pending", step_q.size() != 0, 1);
        if (step_q.size() != 0) begin
          mon_e = step_q.pop_front();
          chk("step_count", io.count, mon_e.cnt);
          chk("step_dir", io.dir, mon_e.dir);
        end
      end
      if (io.index_strobe) begin
        idx_seen++;
        chk("index_pulse_single", idx_prev, 0);
        chk("index_expected_pending", idx_q.size() != 0, 1);
        if (idx_q.size() != 0) begin
          mon_idx = idx_q.pop_front();
          chk("index_pos", io.index_pos, mon_idx);
        end
      end
    end
    idx_prev = io.index_strobe;
  end

  task automatic drive_edge(input bit fwd);
    if (fwd) begin
      if (pa == pb) pa = ~pa; else pb = ~pb;
    end else begin
      if (pa == pb) pb = ~pb; else pa = ~pa;
    end
    io.a = pa;
    io.b = pb;
  endtask

  task automatic edge_step(input bit fwd, input int period);
    @(negedge clk);
    drive_edge(fwd);
    cnt_m = fwd ? cnt_m + 1 : cnt_m - 1;
    step_q.push_back('{cnt_m, fwd});
    repeat (period) @(posedge clk);
  endtask

  task automatic wait_vel(output longint t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 3 * VEL_WINDOW; i++) begin
      @(negedge clk);
      if (io.vel_strobe) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    io.a = 0; io.b = 0; io.z = 0; io.load = 0; io.load_value = '0;
    io.idx_clr_en = 0; io.fault_clr = 0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset_state");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);

    // 8 forward then 8 reverse quadrature cycles.
    s0 = steps_seen;
    for (int i = 0; i < 32; i++) edge_step(1'b1, 20);
    #1;
    chk("fwd_count", io.count, 32);
    chk("fwd_dir", io.dir, 1);
    chk("fwd_steps", steps_seen - s0, 32);
    s0 = steps_seen;
    for (int i = 0; i < 32; i++) edge_step(1'b0, 20);
    #1;
    chk("rev_count", io.count, 0);
    chk("rev_dir", io.dir, 0);
    chk("rev_steps", steps_seen - s0, 32);

    // Single A edge: count moves on the 6th edge after sampling.
    @(negedge clk);
    drive_edge(1'b1);
    cnt_m = cnt_m + 1;
    step_q.push_back('{cnt_m, 1'b1});
    repeat (5) @(posedge clk);
    #1 chk("latency_edge5_unchanged", io.count, 0);
    @(posedge clk);
    #1 chk("latency_edge6_updated", io.count, 1);
    repeat (10) @(posedge clk);

    // 2-clock glitch on B must be invisible.
    s0 = steps_seen;
    @(negedge clk) io.b = 1'b1;
    @(negedge clk);
    @(negedge clk) io.b = pb;
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_count", io.count, 1);
    chk("glitch_fault", io.fault, 0);
    chk("glitch_steps", steps_seen - s0, 0);
    edge_step(1'b0, 20);

    // Illegal transitions: both bits change together.
    @(negedge clk);
    pa = ~pa; pb = ~pb; io.a = pa; io.b = pb;
    repeat (10) @(posedge clk);
    #1;
    chk("illegal_count_held", io.count, cnt_m);
    chk("illegal_fault", io.fault, 1);
    chk("illegal_err1", io.err_count, 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pa = ~pa; pb = ~pb; io.a = pa; io.b = pb;
      repeat (5) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    #1;
    chk("err_saturated", io.err_count, 255);
    chk("err_fault_sticky", io.fault, 1);
    chk("err_count_held", io.count, cnt_m);
    @(negedge clk) io.fault_clr = 1'b1;
    @(negedge clk) io.fault_clr = 1'b0;
    chk("fault_cleared", io.fault, 0);
    chk("err_cleared", io.err_count, 0);
    edge_step(1'b1, 20);
    edge_step(1'b1, 20);

    // Index capture without and with clear.
    @(negedge clk);
    io.load_value = 100; io.load = 1'b1; cnt_m = 100;
    @(negedge clk) io.load = 1'b0;
    chk("load_100", io.count, 100);
    @(negedge clk) io.z = 1'b1;
    idx_q.push_back(100);
    repeat (10) @(posedge clk);
    #1 chk("index_no_clear_count", io.count, 100);
    @(negedge clk) io.z = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) begin io.idx_clr_en = 1'b1; io.z = 1'b1; end
    idx_q.push_back(100);
    cnt_m = 0;
    repeat (10) @(posedge clk);
    #1 chk("index_clear_count", io.count, 0);
    @(negedge clk) begin io.z = 1'b0; io.idx_clr_en = 1'b0; end
    repeat (10) @(posedge clk);
    chk("index_strobes", idx_seen, 2);

    // Preset to all-ones then wrap on a forward step.
    @(negedge clk);
    io.load_value = 32'hFFFF_FFFF; io.load = 1'b1; cnt_m = 32'hFFFF_FFFF;
    @(negedge clk) io.load = 1'b0;
    chk("load_ones", io.count, 32'hFFFF_FFFF);
    edge_step(1'b1, 20);
    #1 chk("wrap_count", io.count, 0);

    // Load landing on the same edge as a step wins.
    @(negedge clk);
    drive_edge(1'b1);
    cnt_m = 32'h1234_5678;
    step_q.push_back('{cnt_m, 1'b1});
    repeat (5) @(posedge clk);
    @(negedge clk) begin io.load_value = 32'h1234_5678; io.load = 1'b1; end
    @(negedge clk) io.load = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("load_over_step", io.count, 32'h1234_5678);

    // Velocity: one forward step every 4 clocks gives 25 per 100-clock window.
    fork
      begin
        while (!vel_done) edge_step(1'b1, 4);
      end
      begin
        repeat (10) @(posedge clk);
        wait_vel(t_prev, vel_ok);
        chk("vel_first_strobe", vel_ok, 1);
        for (int k = 0; k < 3; k++) begin
          wait_vel(t_now, vel_ok);
          chk("vel_strobe_seen", vel_ok, 1);
          chk("velocity", io.velocity, 25);
          chk("vel_period", t_now - t_prev, VEL_WINDOW);
          t_prev = t_now;
        end
        vel_done = 1'b1;
      end
    join
    repeat (20) @(posedge clk);

    // Mid-window reset clears all outputs without waiting for a clock.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid_window");
    pa = 0; pb = 0; io.a = 0; io.b = 0; cnt_m = 0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_count", io.count, 0);
    chk("post_reset_fault", io.fault, 0);

    chk("step_queue_drained", step_q.size(), 0);
    chk("index_queue_drained", idx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
